// File: rtl/ic74ls299_if.sv
// Control and serial-output pins of the 74LS299, grouped by package pin number.
// The eight bidirectional data pins stay plain inout ports on the register itself.
interface ic74ls299_if;
  logic port1;   // S0
  logic port19;  // S1
  logic port2;   // G1_n
  logic port3;   // G2_n
  logic port11;  // SR
  logic port18;  // SL
  logic port8;   // QA'
  logic port13;  // QH'

  modport master (
    output port1, port19, port2, port3, port11, port18,
    input  port8, port13
  );

  modport slave (
    input  port1, port19, port2, port3, port11, port18,
    output port8, port13
  );
endinterface

// File: rtl/ic74ls299.sv
// 8-bit universal shift/storage register with tri-state multiplexed I/O,
// pin-for-pin with the SN74LS299 (ports named by package pin).
module ic74ls299 (
  input  logic           port12,  // CLK
  input  logic           port9,   // CLR_n
  input  logic           port10,  // GND
  input  logic           port20,  // VCC
  ic74ls299_if.slave     bus,
  inout  wire            port7,   // A/QA
  inout  wire            port17,  // B/QB
  inout  wire            port6,   // C/QC
  inout  wire            port16,  // D/QD
  inout  wire            port5,   // E/QE
  inout  wire            port15,  // F/QF
  inout  wire            port4,   // G/QG
  inout  wire            port14   // H/QH
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  mode_e      mode;
  logic [7:0] q_q;
  logic [7:0] q_d;
  logic [7:0] pin_in;
  logic       oe;
  logic       unused_pwr;

  assign unused_pwr = port10 ^ port20;

  assign pin_in = {port14, port4, port15, port5, port16, port6, port17, port7};

  always_comb begin
    mode = mode_e'({bus.port19, bus.port1});
    q_d  = q_q;
    case (mode)
      MODE_HOLD: q_d = q_q;
      MODE_SHR:  q_d = {q_q[6:0], bus.port11};
      MODE_SHL:  q_d = {bus.port18, q_q[7:1]};
      MODE_LOAD: q_d = pin_in;
    endcase
  end

  always_ff @(posedge port12 or negedge port9) begin
    if (!port9) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Load mode floats the pins regardless of the enables so external data can be captured.
  assign oe = !bus.port2 && !bus.port3 && (mode != MODE_LOAD);

  assign port7  = oe ? q_q[0] : 1'bz;
  assign port17 = oe ? q_q[1] : 1'bz;
  assign port6  = oe ? q_q[2] : 1'bz;
  assign port16 = oe ? q_q[3] : 1'bz;
  assign port5  = oe ? q_q[4] : 1'bz;
  assign port15 = oe ? q_q[5] : 1'bz;
  assign port4  = oe ? q_q[6] : 1'bz;
  assign port14 = oe ? q_q[7] : 1'bz;

  assign bus.port8  = q_q[0];
  assign bus.port13 = q_q[7];

endmodule

// File: tb/tb_ic74ls299.sv
// Self-checking bench for ic74ls299: directed pin-level scenarios plus randomized
// stimulus compared every cycle against a byte-level behavioural model.
module tb_ic74ls299;

  logic       clk;
  logic       rst_n;
  logic [7:0] tb_data;
  logic       tb_oe;
  logic       cmp_en;
  logic [7:0] m;
  int         checks;
  int         failures;
  wire  [7:0] io;

  ic74ls299_if bus ();

  ic74ls299 dut (
    .port12 (clk),
    .port9  (rst_n),
    .port10 (1'b0),
    .port20 (1'b1),
    .bus    (bus),
    .port7  (io[0]),
    .port17 (io[1]),
    .port6  (io[2]),
    .port16 (io[3]),
    .port5  (io[4]),
    .port15 (io[5]),
    .port4  (io[6]),
    .port14 (io[7])
  );

  // The bench drives the pins exactly when the register must not; any stray
  // register drive then corrupts the value the bench sees on the pins.
  assign tb_oe = !(!bus.port2 && !bus.port3 && ({bus.port19, bus.port1} != 2'b11));
  assign io    = tb_oe ? tb_data : 8'hzz;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial m = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= 8'h00;
    end else begin
      case ({bus.port19, bus.port1})
        2'b01:   m <= (m * 8'd2) + {7'd0, bus.port11};
        2'b10:   m <= (m / 8'd2) + (bus.port18 ? 8'd128 : 8'd0);
        2'b11:   m <= tb_data;
        default: m <= m;
      endcase
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_io", io, tb_oe ? tb_data : m);
      chk("cyc_qa_s", {7'd0, bus.port8}, {7'd0, m[0]});
      chk("cyc_qh_s", {7'd0, bus.port13}, {7'd0, m[7]});
    end
  end

  task automatic drive(input logic [1:0] md, input logic g1, input logic g2,
                       input logic sr, input logic sl, input logic [7:0] d);
    {bus.port19, bus.port1} = md;
    bus.port2  = g1;
    bus.port3  = g2;
    bus.port11 = sr;
    bus.port18 = sl;
    tb_data    = d;
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic drive_rand();
    drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom), 1'($urandom), 8'($urandom));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cmp_en   = 1'b0;
    rst_n    = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(2);
    chk("rst_io", io, 8'h00);
    chk("rst_qa_s", {7'd0, bus.port8}, 8'h00);
    chk("rst_qh_s", {7'd0, bus.port13}, 8'h00);
    cmp_en = 1'b1;
    rst_n  = 1'b1;

    // parallel load then read back on the pins
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C);
    tick(1);
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(1);
    chk("load_io", io, 8'h3C);
    chk("load_qa_s", {7'd0, bus.port8}, 8'h00);
    chk("load_qh_s", {7'd0, bus.port13}, 8'h00);

    // asynchronous clear mid-cycle
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    tick(1);
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(1);
    chk("pre_clr_io", io, 8'hA5);
    rst_n = 1'b0;
    #1;
    chk("clr_io", io, 8'h00);
    chk("clr_qa_s", {7'd0, bus.port8}, 8'h00);
    chk("clr_qh_s", {7'd0, bus.port13}, 8'h00);
    #1;
    rst_n = 1'b1;

    // shift right
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81);
    tick(1);
    drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(1);
    chk("shr1_io", io, 8'h02);
    chk("shr1_qh_s", {7'd0, bus.port13}, 8'h00);
    tick(7);
    chk("shr8_io", io, 8'h00);

    // shift left
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
    tick(1);
    drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick(3);
    chk("shl3_io", io, 8'hE0);
    chk("shl3_qa_s", {7'd0, bus.port8}, 8'h00);
    chk("shl3_qh_s", {7'd0, bus.port13}, 8'h01);

    // output enable and load-mode tri-state
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
    tick(1);
    drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    chk("g1off_io", io, 8'h00);
    chk("g1off_qa_s", {7'd0, bus.port8}, 8'h01);
    chk("g1off_qh_s", {7'd0, bus.port13}, 8'h01);
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
    #1;
    chk("ldz_io", io, 8'h5A);
    tick(1);

    // clock ignored while clear held
    drive(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    rst_n = 1'b0;
    tick(4);
    chk("clr_hold_io", io, 8'h00);
    rst_n = 1'b1;
    tick(1);
    chk("clr_rel_io", io, 8'h01);

    // random traffic, with junk on the inputs between edges
    drive_rand();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      drive_rand();
      #2;
      drive_rand();
      rst_n = ($urandom_range(0, 24) != 0);
    end
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ic74ls299.md
IC74LS299 -- requirements
Module: ic74LS299

Interface
Parameters: none.
REQ-001 The block SHALL model an 8-bit universal shift/storage register with tri-state multiplexed I/O, pin-for-pin with the SN74LS299 20-pin package.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset, with ports named by package pin number.
REQ-003 port12  input  1  CLK, rising-edge clock.
REQ-004 port9  input  1  CLR_n, asynchronous active-low clear (reset).
REQ-005 port1  input  1  S0, mode select bit 0.
REQ-006 port19  input  1  S1, mode select bit 1.
REQ-007 port2  input  1  G1_n, output enable 1, active low.
REQ-008 port3  input  1  G2_n, output enable 2, active low.
REQ-009 port11  input  1  SR, shift-right serial data in.
REQ-010 port18  input  1  SL, shift-left serial data in.
REQ-011 port7, port17, port6, port16, port5, port15, port4, port14  inout  1 each  A/QA, B/QB, C/QC, D/QD, E/QE, F/QF, G/QG, H/QH: bidirectional register bit 0..7.
REQ-012 port8  output  1  QA', serial out of bit 0, never tri-stated.
REQ-013 port13  output  1  QH', serial out of bit 7, never tri-stated.
REQ-014 port10 (GND) and port20 (VCC) SHALL be inputs and SHALL be ignored functionally.

Function
REQ-015 Internal state SHALL be an 8-bit register q[0..7], with q[0]=QA and q[7]=QH.
REQ-016 Mode {S1,S0}=00 SHALL hold: q is unchanged on the clock edge.
REQ-017 Mode 01 SHALL shift right on the rising edge: q[0]<=SR, q[i]<=q[i-1] for i=1..7.
REQ-018 Mode 10 SHALL shift left on the rising edge: q[7]<=SL, q[i]<=q[i+1] for i=0..6.
REQ-019 Mode 11 SHALL parallel-load on the rising edge: q[i]<=value present on I/O pin i.
REQ-020 Mode, SR, SL and I/O pin values SHALL be sampled at the rising edge only; changes between edges SHALL have no effect on q.
REQ-021 I/O pins SHALL drive q[i] only when G1_n=0, G2_n=0 and {S1,S0}!=11; otherwise they SHALL be high-Z.
REQ-022 In mode 11, I/O pins SHALL be high-Z regardless of G1_n/G2_n, so that external data can be loaded without contention.
REQ-023 Output-enable changes SHALL affect I/O drive combinationally and SHALL NOT alter q.
REQ-024 QA' and QH' SHALL continuously reflect q[0] and q[7], independent of output enables and mode.
REQ-025 Load-mode latency: a value SHALL be visible on the I/O pins one edge after load, once the block has left mode 11 with outputs enabled.
REQ-026 Shift latency: serial data SHALL appear on the opposite serial output after 8 rising edges.
REQ-027 X/Z on a sampled I/O pin in mode 11 SHALL load X into that bit; no other bit SHALL be affected.

Reset
REQ-028 CLR_n=0 SHALL immediately clear q to 8'h00 without waiting for a clock edge, so QA'=QH'=0 and any enabled I/O pins read 0.
REQ-029 While CLR_n=0, rising clock edges SHALL be ignored in every mode.
REQ-030 Clear SHALL NOT override tri-state control: I/O drive SHALL still follow REQ-021.
REQ-031 Operation SHALL resume on the first rising edge after CLR_n returns high; release coincident with an edge SHALL NOT be required to capture.

Verification
REQ-032 Pulse CLR_n low for 2 ns mid-cycle with q=8'hA5 -> q reads 8'h00 immediately and QA'=QH'=0.
REQ-033 Mode 11, drive pins 8'h3C, one edge, then release the pins, mode 00, G1_n=G2_n=0 -> I/O reads 8'h3C (QA..QH = 0,0,1,1,1,1,0,0) and QA'=0, QH'=0.
REQ-034 Load 8'h81, mode 01, SR=0, 1 edge -> q=8'h02, QH'=0; 7 more edges -> q=8'h00.
REQ-035 Load 8'h01, mode 10, SL=1, 3 edges -> q=8'hE0 with bit0 shifted out; QA'=0 and QH'=1.
REQ-036 q=8'hFF, G1_n=1 -> all I/O pins high-Z while QA'=QH'=1; G1_n=G2_n=0 with mode 11 -> pins remain high-Z.
REQ-037 Hold CLR_n=0 in mode 01 with SR=1 for 4 edges -> q stays 8'h00; release, 1 edge -> q=8'h01.
